// File: rtl/mem_rr_arbiter_if.sv
// Requester, response and memory-side signals of the two-requester round-robin memory arbiter.
// The master modport is the environment side (bus masters plus the memory), slave is the arbiter.
interface mem_rr_arbiter_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  req0_valid;
    logic                  req0_wr_rd;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [WIDTH-1:0]      req0_wdata;
    logic                  req0_gnt;

    logic                  req1_valid;
    logic                  req1_wr_rd;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [WIDTH-1:0]      req1_wdata;
    logic                  req1_gnt;

    logic                  rsp_valid;
    logic                  rsp_id;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  rsp_err;

    logic                  mem_valid;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ready;

    modport master (
        output req0_valid, req0_wr_rd, req0_addr, req0_wdata,
        output req1_valid, req1_wr_rd, req1_addr, req1_wdata,
        input  req0_gnt, req1_gnt,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  req0_valid, req0_wr_rd, req0_addr, req0_wdata,
        input  req1_valid, req1_wr_rd, req1_addr, req1_wdata,
        output req0_gnt, req1_gnt,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter sequencing one transaction at a time into a valid/ready memory.
// Define MEM_ARB_TIMEOUT_EN to bound the wait for mem_ready to TIMEOUT cycles and report rsp_err.
module mem_rr_arbiter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              res,
    mem_rr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state;
    logic                  last_gnt;
    logic                  gnt0_c;
    logic                  gnt1_c;
    logic                  tmo_hit_c;
    logic                  mem_valid_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;
    logic [WIDTH-1:0]      rsp_rdata_q;

    if (TIMEOUT == 0) begin : g_timeout_chk
        $error("mem_rr_arbiter: TIMEOUT must be at least 1");
    end

    // Grants only in IDLE; on contention the requester that did not win last time goes first.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (res && state == IDLE) begin
            gnt0_c = bus.req0_valid && (!bus.req1_valid || last_gnt);
            gnt1_c = bus.req1_valid && (!bus.req0_valid || !last_gnt);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             rsp_err_q;

    assign tmo_hit_c = (state == ISSUE) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Counter sits at zero outside ISSUE, so it starts clean on every entry.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            tmo_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state != ISSUE) begin
                tmo_cnt <= '0;
            end else if (!tmo_hit_c) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (state == ISSUE && (bus.mem_ready || tmo_hit_c)) begin
                rsp_err_q <= !bus.mem_ready;
            end
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign tmo_hit_c   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Sequencer: latch the winner, hold the memory request until ready, then pulse the response.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0_c || gnt1_c) begin
                        state       <= ISSUE;
                        last_gnt    <= gnt1_c;
                        mem_valid_q <= 1'b1;
                        mem_wr_rd_q <= gnt1_c ? bus.req1_wr_rd : bus.req0_wr_rd;
                        mem_addr_q  <= gnt1_c ? bus.req1_addr  : bus.req0_addr;
                        mem_wdata_q <= gnt1_c ? bus.req1_wdata : bus.req0_wdata;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready || tmo_hit_c) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= last_gnt;
                        rsp_rdata_q <= (bus.mem_ready && !mem_wr_rd_q) ? bus.mem_rdata : '0;
                        mem_valid_q <= 1'b0;
                        mem_wr_rd_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_gnt  = gnt0_c;
    assign bus.req1_gnt  = gnt1_c;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_wr_rd = mem_wr_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
